// File: rtl/crash_display_ctrl.sv
// crash_display_ctrl
//   Chooses the colour mode of the crash-indicator VGA display from a raw
//   crash-sensor input. The sensor is synchronised and debounced, then a
//   SAFE / ALERT / CRASH state machine counts frames to blink the display
//   while a crash is suspected and to confirm a sustained crash. The colour
//   register only loads on frame_start, so a frame never shows mixed colours.
//
// Ports
//   clk           in   pixel clock (25 MHz), sole clock
//   reset         in   synchronous, active-high reset
//   frame_start   in   one-cycle pulse at the end of every frame
//   crash_in      in   raw asynchronous sensor level, 1 = crash
//   ack           in   operator clear, level-sampled every cycle
//   color_select  out  1 = red, 0 = green
//   state_o       out  SAFE=0, ALERT=1, CRASH=2
//   crash_latched out  high while in CRASH
//   crash_count   out  confirmed crashes, saturating at 255
module crash_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLINK_FRAMES    = 15,
  parameter int CONFIRM_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       crash_in,
  input  logic       ack,
  output logic       color_select,
  output logic [1:0] state_o,
  output logic       crash_latched,
  output logic [7:0] crash_count
);

  // Counters are sized to hold their terminal value; the +1 keeps a
  // parameter of 1 from collapsing a counter to zero width.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CF_W = $clog2(CONFIRM_FRAMES + 1);
  localparam int BF_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CF_W-1:0] CF_LAST = CF_W'(CONFIRM_FRAMES - 1);
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    ALERT = 2'd1,
    CRASH = 2'd2
  } state_t;

  logic            sync1;
  logic            s;
  logic            db;
  logic [DB_W-1:0] db_cnt;

  state_t          state;
  logic [CF_W-1:0] frame_cnt;
  logic [BF_W-1:0] blink_cnt;
  logic            blink_phase;

  // Two-flop synchroniser followed by a debouncer: db only follows s after
  // s has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any
  // return to agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= crash_in;
      s     <= sync1;
      if (s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // State machine plus frame-gated colour register. The colour loaded at a
  // frame_start reflects the state before that edge, so a transition shows
  // on screen at the first frame boundary after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SAFE;
      frame_cnt     <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b1;
      crash_count   <= 8'd0;
      crash_latched <= 1'b0;
      color_select  <= 1'b0;
    end else begin
      if (frame_start) begin
        case (state)
          SAFE:    color_select <= 1'b0;
          ALERT:   color_select <= blink_phase;
          CRASH:   color_select <= 1'b1;
          default: color_select <= 1'b0;
        endcase
      end

      case (state)
        SAFE: begin
          if (db) begin
            state       <= ALERT;
            frame_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
          end
        end

        ALERT: begin
          // A released sensor wins over a coincident frame_start.
          if (!db) begin
            state <= SAFE;
          end else if (frame_start) begin
            if (frame_cnt == CF_LAST) begin
              state         <= CRASH;
              crash_latched <= 1'b1;
              if (crash_count != 8'hFF) begin
                crash_count <= crash_count + 8'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + CF_W'(1);
            end
            if (blink_cnt == BF_LAST) begin
              blink_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_cnt <= blink_cnt + BF_W'(1);
            end
          end
        end

        CRASH: begin
          // The operator can only clear once the sensor has settled low.
          if (ack && !db) begin
            state         <= SAFE;
            crash_latched <= 1'b0;
          end
        end

        default: begin
          state         <= SAFE;
          crash_latched <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_crash_display_ctrl.sv
// tb_crash_display_ctrl
//   Directed bench for crash_display_ctrl with small parameters
//   (DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, CONFIRM_FRAMES=5). Expected colours
//   are queued when a frame_start pulse is driven and popped when the
//   colour register has loaded.
module tb_crash_display_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic       crash_in;
  logic       ack;
  logic       color_select;
  logic [1:0] state_o;
  logic       crash_latched;
  logic [7:0] crash_count;

  int checks = 0;
  int errors = 0;
  logic colorQ[$];

  crash_display_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_FRAMES   (2),
    .CONFIRM_FRAMES (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .crash_in     (crash_in),
    .ack          (ack),
    .color_select (color_select),
    .state_o      (state_o),
    .crash_latched(crash_latched),
    .crash_count  (crash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One frame: 19 idle cycles then a frame_start pulse whose expected
  // colour goes on the scoreboard and is compared once loaded.
  task automatic applyStimulus(input logic expColor, input string tag);
    tick(19);
    frame_start = 1'b1;
    colorQ.push_back(expColor);
    tick();
    frame_start = 1'b0;
    if (colorQ.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      checkOutput(tag, {7'd0, color_select}, {7'd0, colorQ.pop_front()});
    end
  endtask

  // One full crash: debounce in, five back-to-back frame pulses to confirm,
  // release the sensor, then acknowledge.
  task automatic doCrash(input bit chk);
    crash_in = 1'b1;
    tick(7);
    if (chk) checkOutput("fast_alert", {6'd0, state_o}, 8'd1);
    frame_start = 1'b1;
    tick(4);
    if (chk) checkOutput("fast_pre_confirm", {6'd0, state_o}, 8'd1);
    tick();
    frame_start = 1'b0;
    if (chk) checkOutput("fast_confirm", {6'd0, state_o}, 8'd2);
    crash_in = 1'b0;
    tick(7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (chk) checkOutput("fast_ack", {6'd0, state_o}, 8'd0);
  endtask

  initial begin
    int waitCycles;
    reset       = 1'b1;
    frame_start = 1'b0;
    crash_in    = 1'b0;
    ack         = 1'b0;

    // Reset and idle frames
    tick(3);
    reset = 1'b0;
    checkOutput("rst_color", {7'd0, color_select}, 8'd0);
    checkOutput("rst_state", {6'd0, state_o}, 8'd0);
    checkOutput("rst_count", crash_count, 8'd0);
    checkOutput("rst_latched", {7'd0, crash_latched}, 8'd0);
    for (int f = 0; f < 10; f++) applyStimulus(1'b0, "idle_color");
    checkOutput("idle_state", {6'd0, state_o}, 8'd0);
    checkOutput("idle_count", crash_count, 8'd0);

    // Glitch of 3 cycles is rejected
    crash_in = 1'b1;
    tick(3);
    crash_in = 1'b0;
    tick(10);
    checkOutput("glitch_state", {6'd0, state_o}, 8'd0);
    applyStimulus(1'b0, "glitch_color");
    checkOutput("glitch_state2", {6'd0, state_o}, 8'd0);

    // Confirmed crash: 2 sync + 4 debounce cycles, then the FSM edge
    crash_in = 1'b1;
    tick(6);
    checkOutput("alert_early", {6'd0, state_o}, 8'd0);
    tick();
    checkOutput("alert_entry", {6'd0, state_o}, 8'd1);
    applyStimulus(1'b1, "blink1");
    applyStimulus(1'b1, "blink2");
    applyStimulus(1'b0, "blink3");
    applyStimulus(1'b0, "blink4");
    checkOutput("pre_confirm_state", {6'd0, state_o}, 8'd1);
    applyStimulus(1'b1, "blink5");
    checkOutput("crash_state", {6'd0, state_o}, 8'd2);
    checkOutput("crash_latched", {7'd0, crash_latched}, 8'd1);
    checkOutput("crash_count1", crash_count, 8'd1);
    applyStimulus(1'b1, "crash_color1");
    applyStimulus(1'b1, "crash_color2");

    // Ack ignored while the sensor is still high, accepted after release
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("ack_ignored", {6'd0, state_o}, 8'd2);
    crash_in = 1'b0;
    tick(8);
    checkOutput("crash_holds", {6'd0, state_o}, 8'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("ack_clear", {6'd0, state_o}, 8'd0);
    checkOutput("ack_latched", {7'd0, crash_latched}, 8'd0);
    applyStimulus(1'b0, "ack_color");
    checkOutput("ack_count", crash_count, 8'd1);

    // False alarm: released after 3 frames in ALERT
    crash_in = 1'b1;
    tick(7);
    checkOutput("fa_alert", {6'd0, state_o}, 8'd1);
    applyStimulus(1'b1, "fa_blink1");
    applyStimulus(1'b1, "fa_blink2");
    applyStimulus(1'b0, "fa_blink3");
    crash_in = 1'b0;
    tick(6);
    checkOutput("fa_hold", {6'd0, state_o}, 8'd1);
    tick();
    checkOutput("fa_safe", {6'd0, state_o}, 8'd0);
    checkOutput("fa_count", crash_count, 8'd1);
    applyStimulus(1'b0, "fa_color");

    // Saturation with back-to-back frame pulses
    doCrash(1'b1);
    checkOutput("sat_count2", crash_count, 8'd2);
    for (int k = 0; k < 252; k++) doCrash(1'b0);
    checkOutput("sat_count254", crash_count, 8'd254);
    doCrash(1'b0);
    checkOutput("sat_count255", crash_count, 8'd255);
    doCrash(1'b1);
    doCrash(1'b0);
    checkOutput("sat_hold", crash_count, 8'd255);
    checkOutput("sat_color", {7'd0, color_select}, 8'd1);

    // Reset while in ALERT
    crash_in = 1'b1;
    waitCycles = 0;
    while (state_o != 2'd1 && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("reach_alert", {6'd0, state_o}, 8'd1);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_state", {6'd0, state_o}, 8'd0);
    checkOutput("mid_rst_count", crash_count, 8'd0);
    checkOutput("mid_rst_color", {7'd0, color_select}, 8'd0);
    checkOutput("mid_rst_latched", {7'd0, crash_latched}, 8'd0);
    reset    = 1'b0;
    crash_in = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
